// File: rtl/lane_hit_scorer.sv
// rtl/lane_hit_scorer.sv - lane hit judgement, BCD score and combo engine
//
// Purpose: opens a timed hit window per note pattern, judges rising key
// edges per lane, keeps a saturating N-digit BCD score and a combo count.
// Optional build macro: LANE_HIT_SCORER_PENALTY_EN (wrong-lane presses cost
// one point, clear the combo and raise miss_pulse).
//
// Ports:
//   clk            system clock
//   resetn         asynchronous active-low reset
//   clear          synchronous game reset (same effect as resetn)
//   enable         play enable; low drops to idle
//   note_valid     one-cycle strobe qualifying note_lanes
//   note_lanes     lane pattern of the new note
//   keys           debounced key levels, active high
//   score_bcd      BCD score, digit 0 in [3:0]
//   combo          consecutive fully-cleared notes, saturating at 255
//   active_lanes   lanes still awaiting a press
//   window_active  high while a window is open
//   hit_pulse      at least one correct press judged
//   miss_pulse     note expired/abandoned with lanes left (or wrong press)
module lane_hit_scorer #(
  parameter int LANES          = 4,
  parameter int SCORE_DIGITS   = 3,
  parameter int WINDOW_CYCLES  = 25000000,
  parameter int COMBO_BONUS_AT = 10
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      clear,
  input  logic                      enable,
  input  logic                      note_valid,
  input  logic [LANES-1:0]          note_lanes,
  input  logic [LANES-1:0]          keys,
  output logic [4*SCORE_DIGITS-1:0] score_bcd,
  output logic [7:0]                combo,
  output logic [LANES-1:0]          active_lanes,
  output logic                      window_active,
  output logic                      hit_pulse,
  output logic                      miss_pulse
);

  localparam int CW = $clog2(WINDOW_CYCLES);
  localparam logic [CW-1:0] WIN_LOAD = CW'(WINDOW_CYCLES - 1);
  localparam logic [4*SCORE_DIGITS-1:0] ALL_NINES = {SCORE_DIGITS{4'h9}};

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_WINDOW} state_t;

  state_t                    r_state;
  logic [LANES-1:0]          r_key_d;
  logic [LANES-1:0]          r_active;
  logic [CW-1:0]             r_cnt;
  logic [4*SCORE_DIGITS-1:0] r_score;
  logic [7:0]                r_combo;
  logic                      r_win;
  logic                      r_hit;
  logic                      r_miss;

  function automatic logic [2:0] popcnt(input logic [LANES-1:0] v);
    popcnt = '0;
    for (int i = 0; i < LANES; i++) popcnt = popcnt + 3'(v[i]);
  endfunction

  logic [LANES-1:0]          w_edge;
  logic [LANES-1:0]          w_hits;
  logic [LANES-1:0]          w_rem;
  logic [2:0]                w_nhits;
  logic [3:0]                w_points;
  logic [3:0]                w_add_val;
  logic [7:0]                w_combo_inc;
  logic                      w_new_note;
  logic [4:0]                w_carry;
  logic [4:0]                w_dsum;
  logic [4*SCORE_DIGITS-1:0] w_sum_score;
  logic [4*SCORE_DIGITS-1:0] w_score_next;

  assign w_edge      = keys & ~r_key_d;
  assign w_hits      = w_edge & r_active;
  assign w_rem       = r_active & ~w_edge;
  assign w_nhits     = popcnt(w_hits);
  // Bonus is judged on the combo value held before this cycle's update.
  assign w_points    = (int'(r_combo) >= COMBO_BONUS_AT) ? {w_nhits, 1'b0} : {1'b0, w_nhits};
  assign w_combo_inc = (r_combo == 8'hFF) ? 8'hFF : r_combo + 8'd1;
  assign w_new_note  = note_valid && (note_lanes != '0);

`ifdef LANE_HIT_SCORER_PENALTY_EN
  logic [LANES-1:0]          w_wrong;
  logic [2:0]                w_nwrong;
  logic [2:0]                w_sub_val;
  logic [2:0]                w_borrow;
  logic [4*SCORE_DIGITS-1:0] w_dif_score;

  assign w_wrong  = w_edge & ~r_active;
  assign w_nwrong = popcnt(w_wrong);
  // Hits and penalties are netted first so saturation/flooring sees one value.
  assign w_add_val = (w_points >= {1'b0, w_nwrong}) ? w_points - {1'b0, w_nwrong} : 4'd0;
  assign w_sub_val = (w_points >= {1'b0, w_nwrong}) ? 3'd0 : 3'({1'b0, w_nwrong} - w_points);

  always_comb begin
    w_dif_score = r_score;
    w_borrow    = w_sub_val;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      if (r_score[4*i +: 4] < {1'b0, w_borrow}) begin
        w_dif_score[4*i +: 4] = r_score[4*i +: 4] + 4'd10 - {1'b0, w_borrow};
        w_borrow = 3'd1;
      end else begin
        w_dif_score[4*i +: 4] = r_score[4*i +: 4] - {1'b0, w_borrow};
        w_borrow = 3'd0;
      end
    end
    if (w_borrow != 3'd0) w_dif_score = '0;
  end

  assign w_score_next = (w_sub_val != 3'd0) ? w_dif_score : w_sum_score;
`else
  assign w_add_val    = w_points;
  assign w_score_next = w_sum_score;
`endif

  // Ripple BCD add; the first digit may absorb up to 8, later digits a carry of 1.
  always_comb begin
    w_sum_score = r_score;
    w_carry     = {1'b0, w_add_val};
    w_dsum      = '0;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      w_dsum = {1'b0, r_score[4*i +: 4]} + w_carry;
      if (w_dsum > 5'd9) begin
        w_sum_score[4*i +: 4] = 4'(w_dsum - 5'd10);
        w_carry = 5'd1;
      end else begin
        w_sum_score[4*i +: 4] = w_dsum[3:0];
        w_carry = 5'd0;
      end
    end
    if (w_carry != 5'd0) w_sum_score = ALL_NINES;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_key_d  <= '1;
      r_active <= '0;
      r_cnt    <= '0;
      r_score  <= '0;
      r_combo  <= '0;
      r_win    <= 1'b0;
      r_hit    <= 1'b0;
      r_miss   <= 1'b0;
    end else if (clear) begin
      r_state  <= S_IDLE;
      r_key_d  <= '1;
      r_active <= '0;
      r_cnt    <= '0;
      r_score  <= '0;
      r_combo  <= '0;
      r_win    <= 1'b0;
      r_hit    <= 1'b0;
      r_miss   <= 1'b0;
    end else begin
      r_key_d <= keys;
      r_hit   <= 1'b0;
      r_miss  <= 1'b0;
      if (!enable) begin
        // Dropping out of play abandons the window silently.
        r_state  <= S_IDLE;
        r_active <= '0;
        r_win    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_ARMED;
          S_ARMED: begin
            if (w_new_note) begin
              r_active <= note_lanes;
              r_cnt    <= WIN_LOAD;
              r_win    <= 1'b1;
              r_state  <= S_WINDOW;
            end
          end
          S_WINDOW: begin
            r_score <= w_score_next;
            r_hit   <= (w_hits != '0);
            if (w_new_note) begin
              // Old pattern is judged first, then replaced in place.
              if (w_rem != '0) begin
                r_miss  <= 1'b1;
                r_combo <= '0;
              end else begin
                r_combo <= w_combo_inc;
              end
              r_active <= note_lanes;
              r_cnt    <= WIN_LOAD;
            end else if (w_rem == '0) begin
              // Clearing on the expiry cycle still counts as a hit.
              r_combo  <= w_combo_inc;
              r_active <= '0;
              r_win    <= 1'b0;
              r_state  <= S_ARMED;
            end else if (r_cnt == '0) begin
              r_miss   <= 1'b1;
              r_combo  <= '0;
              r_active <= '0;
              r_win    <= 1'b0;
              r_state  <= S_ARMED;
            end else begin
              r_cnt    <= r_cnt - 1'b1;
              r_active <= w_rem;
            end
`ifdef LANE_HIT_SCORER_PENALTY_EN
            if (w_wrong != '0) begin
              r_miss  <= 1'b1;
              r_combo <= '0;
            end
`endif
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign score_bcd     = r_score;
  assign combo         = r_combo;
  assign active_lanes  = r_active;
  assign window_active = r_win;
  assign hit_pulse     = r_hit;
  assign miss_pulse    = r_miss;

endmodule
